// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read per cycle to the I-cache and queues {pc, instr} pairs for decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined; otherwise perf_* read 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_en,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t         r_mem [QUEUE_DEPTH];
  logic [31:0]    r_pc;
  logic [31:0]    r_req_pc;
  logic           r_inflight;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_pop;
  logic           w_push;
  logic           w_rsp;
  logic           w_full;
  logic [OW-1:0]  w_occ;
  entry_t         w_head;

  assign out_valid = !rst && (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_count == CW'(QUEUE_DEPTH));

  // Credits: queued entries plus the request whose data is still coming back.
  assign w_occ   = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
  assign ic_en   = !rst && !redirect_valid && (w_occ < OW'(QUEUE_DEPTH));
  assign ic_addr = r_pc;

  // A response only counts if we asked for it, so a stale one after reset is ignored.
  assign w_rsp  = ic_rvalid && r_inflight;
  assign w_push = w_rsp && !redirect_valid && (!w_full || w_pop);

  assign w_head    = r_mem[r_rptr];
  assign out_pc    = out_valid ? w_head.pc    : 32'h0000_0000;
  assign out_instr = out_valid ? w_head.instr : 32'h0000_0013;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= ic_en;
      if (redirect_valid) begin
        r_pc    <= redirect_pc & ~32'h0000_0003;
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (ic_en) begin
          r_req_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: queue storage is not reset; occupancy and out_valid gate every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{pc: r_req_pc, instr: ic_rdata};
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetched;
  logic [31:0] r_dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetched <= '0;
      r_dropped <= '0;
    end else begin
      if (w_pop) r_fetched <= r_fetched + 32'd1;
      if (redirect_valid)
        r_dropped <= r_dropped + 32'(r_count) - 32'(w_pop) + 32'(w_rsp);
    end
  end

  assign perf_fetched = r_fetched;
  assign perf_dropped = r_dropped;
`else
  assign perf_fetched = 32'h0000_0000;
  assign perf_dropped = 32'h0000_0000;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_rsp && !redirect_valid && w_full && !w_pop))
        else $error("fetch_unit: cache response arrived with the instruction queue full");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, an ideal 1-cycle cache, a program-order model checked
// every cycle at the falling edge, and literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ic_rvalid = 1'b0;
  logic [31:0] ic_rdata = '0;
  logic        out_ready = 1'b0;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;

  fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_en(ic_en), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache contents: a fixed function of the address, distinct from the address itself.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Cache response for the next cycle, produced by the compare process.
  logic        nv = 1'b0;
  logic [31:0] nd = '0;

  // Program-order model: what the fetch stream must look like, independent of queue internals.
  logic [31:0] m_issue_pc   = RST_PC;
  logic [31:0] m_deliver_pc = RST_PC;
  logic [31:0] m_fetched    = '0;
  logic [31:0] m_dropped    = '0;
  int          m_issued     = 0;
  int          m_delivered  = 0;
  logic        m_last       = 1'b0;

  always @(negedge clk) begin : compare
    logic exp_valid;
    logic exp_en;
    logic pop;
    if (rst) begin
      check("rst_ic_en", ic_en, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      m_issue_pc   = RST_PC;
      m_deliver_pc = RST_PC;
      m_fetched    = '0;
      m_dropped    = '0;
      m_issued     = 0;
      m_delivered  = 0;
      m_last       = 1'b0;
      nv = 1'b0;
      nd = '0;
    end else begin
      // Entries waiting = issued - delivered, minus the one whose data is still returning.
      exp_valid = (m_issued - m_delivered - int'(m_last)) > 0;
      pop       = exp_valid && out_ready;
      exp_en    = !redirect_valid && ((m_issued - m_delivered - int'(pop)) < DEPTH);

      check("ic_en", ic_en, exp_en);
      check("ic_addr", ic_addr, m_issue_pc);
      check("out_valid", out_valid, exp_valid);
      check("out_pc", out_pc, exp_valid ? m_deliver_pc : 32'h0000_0000);
      check("out_instr", out_instr, exp_valid ? mem_word(m_deliver_pc) : 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_dropped", perf_dropped, m_dropped);
`else
      check("perf_fetched", perf_fetched, 32'h0);
      check("perf_dropped", perf_dropped, 32'h0);
`endif

      if (pop) begin
        m_delivered++;
        m_deliver_pc += 32'd4;
        m_fetched    += 32'd1;
      end
      if (redirect_valid) begin
        m_dropped   += 32'(m_issued - m_delivered);
        m_issue_pc   = redirect_pc & ~32'h3;
        m_deliver_pc = redirect_pc & ~32'h3;
        m_issued     = 0;
        m_delivered  = 0;
        m_last       = 1'b0;
      end else begin
        if (exp_en) begin
          m_issued++;
          m_issue_pc += 32'd4;
        end
        m_last = exp_en;
      end
      nv = ic_en;
      nd = mem_word(ic_addr);
    end
  end

  // One clock cycle: drive inputs just after the rising edge, return with outputs settled.
  task automatic step(input logic r, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic inj);
    @(posedge clk);
    #1;
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    ic_rvalid      = nv | inj;
    ic_rdata       = inj ? 32'hDEAD_BEEF : nd;
    #2;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run(input logic rdy);
    step(1'b0, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset release, free-running decode.
    do_reset();
    run(1'b1);
    check("c0_ic_en", ic_en, 1'b1);
    check("c0_ic_addr", ic_addr, 32'h0);
    check("c0_out_valid", out_valid, 1'b0);
    run(1'b1);
    check("c1_out_valid", out_valid, 1'b0);
    run(1'b1);
    check("c2_out_valid", out_valid, 1'b1);
    check("c2_out_pc", out_pc, 32'h0);
    check("c2_out_instr", out_instr, 32'hC0DE_0000);
    run(1'b1);
    check("c3_out_pc", out_pc, 32'h4);
    repeat (6) run(1'b1);

    // Decode stalled: queue fills to depth, fetch stops, head holds.
    do_reset();
    repeat (10) run(1'b0);
    check("stall_ic_en", ic_en, 1'b0);
    check("stall_ic_addr", ic_addr, 32'h10);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_out_pc", out_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      run(1'b1);
      check("release_out_pc", out_pc, 32'(4 * i));
    end

    // Redirect with three queued entries and one response in flight.
    do_reset();
    repeat (4) run(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("redir_ic_en", ic_en, 1'b0);
    run(1'b1);
    check("redir_r1_ic_addr", ic_addr, 32'h100);
    check("redir_r1_ic_en", ic_en, 1'b1);
    check("redir_r1_out_valid", out_valid, 1'b0);
    run(1'b1);
    check("redir_r2_out_valid", out_valid, 1'b0);
    run(1'b1);
    check("redir_r3_out_valid", out_valid, 1'b1);
    check("redir_r3_out_pc", out_pc, 32'h100);
    check("redir_r3_out_instr", out_instr, 32'hC0DE_0100);
`ifdef FETCH_PERF_CNT_EN
    check("redir_r3_dropped", perf_dropped, 32'd4);
`endif

    // Redirect in the same cycle as a pop.
    repeat (3) run(1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
    check("pop_redir_out_valid", out_valid, 1'b1);
    check("pop_redir_out_pc", out_pc, 32'h110);
    repeat (3) run(1'b1);
    check("pop_redir_target", out_pc, 32'h2000);
`ifdef FETCH_PERF_CNT_EN
    check("pop_redir_fetched", perf_fetched, 32'd5);
`endif

    // Back-to-back redirects: the last one wins.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_4001, 1'b0);
    run(1'b1);
    check("b2b_ic_addr", ic_addr, 32'h4000);
    run(1'b1);
    run(1'b1);
    check("b2b_out_pc", out_pc, 32'h4000);

    // PC wrap at the top of the address space.
    run(1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (3) run(1'b1);
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    run(1'b1);
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    run(1'b1);
    check("wrap_pc2", out_pc, 32'h0000_0000);

    // Intermittent decode backpressure.
    for (int i = 0; i < 20; i++) run((i % 3) != 0);

    // Reset pulse mid-stream with a request outstanding, plus a stale response afterwards.
    repeat (3) run(1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_ic_en", ic_en, 1'b1);
    check("rst_mid_ic_addr", ic_addr, RST_PC);
    check("rst_mid_fetched", perf_fetched, 32'h0);
    check("rst_mid_dropped", perf_dropped, 32'h0);
    run(1'b1);
    check("rst_mid_c1_out_valid", out_valid, 1'b0);
    run(1'b1);
    check("rst_mid_c2_out_pc", out_pc, RST_PC);
    check("rst_mid_c2_out_instr", out_instr, 32'hC0DE_0000);
    repeat (4) run(1'b1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
